// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: op-type encodings and register-id width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rob_pkg;

    localparam logic [2:0] ROB_ALU    = 3'd0;
    localparam logic [2:0] ROB_STORE  = 3'd1;
    localparam logic [2:0] ROB_BRANCH = 3'd2;
    localparam logic [2:0] ROB_JAL    = 3'd3;
    localparam logic [2:0] ROB_JALR   = 3'd4;

    localparam int REG_W = 5;

endpackage

// File: rtl/rob_query_port.sv
// One operand query port: tag lookup into the entry table, optional same-cycle writeback bypass (ROB_BYPASS_EN).
// Latency: combinational.
// Backpressure: none; pending=1 tells the consumer the value is not yet available.
module rob_query_port #(
    parameter int DEPTH    = 32,
    parameter int WB_PORTS = 3,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic [IDX_W-1:0] id,
    input  logic [DEPTH-1:0] avail,
    input  logic [31:0]      qv      [DEPTH],
    input  logic [WB_PORTS-1:0] wb_hit,
    input  logic [IDX_W-1:0] wb_id   [WB_PORTS],
    input  logic [31:0]      wb_val  [WB_PORTS],
    output logic             pending,
    output logic [31:0]      val
);

`ifdef ROB_BYPASS_EN
    // Registered lookup, overridden by a live writeback to the same tag; later ports win.
    always_comb begin
        pending = !avail[id];
        val     = qv[id];
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_hit[k] && (wb_id[k] == id)) begin
                pending = 1'b0;
                val     = wb_val[k];
            end
        end
    end
`else
    // Registered state only: a writeback becomes visible the cycle after it lands.
    always_comb begin
        pending = !avail[id];
        val     = qv[id];
    end

    logic unused_wb;
    always_comb begin
        unused_wb = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            unused_wb = unused_wb ^ wb_hit[k] ^ (^wb_id[k]) ^ (^wb_val[k]);
        end
    end
`endif

endmodule

// File: rtl/reorder_buffer_p.sv
// In-order-commit reorder buffer with multi-port writeback, operand queries and one-cycle flush (bypass: ROB_BYPASS_EN).
// Latency: append/writeback take effect at the edge; commit/flush/predictor outputs are registered, valid next cycle.
// Backpressure: appends are dropped when full or during flush; commit stalls until the head entry is ready.
module reorder_buffer_p
    import rob_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int WB_PORTS  = 3,
    parameter int NUM_QUERY = 2,
    parameter int ADDR_W    = 17,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        append_en,
    input  logic [2:0]                  append_type,
    input  logic [REG_W-1:0]            append_rd,
    input  logic [ADDR_W-1:0]           append_pc,
    input  logic [ADDR_W-1:0]           append_info,
    input  logic [ADDR_W-1:0]           append_pred_target,
    input  logic                        append_pred_taken,
    input  logic [WB_PORTS-1:0]         wb_en,
    input  logic [WB_PORTS*IDX_W-1:0]   wb_id,
    input  logic [WB_PORTS*32-1:0]      wb_val,
    input  logic [NUM_QUERY*IDX_W-1:0]  q_id,
    output logic [NUM_QUERY-1:0]        q_pending,
    output logic [NUM_QUERY*32-1:0]     q_val,
    output logic [IDX_W-1:0]            next_id,
    output logic [IDX_W:0]              count,
    output logic                        full,
    output logic                        empty,
    output logic                        flush,
    output logic [ADDR_W-1:0]           flush_pc,
    output logic                        rf_we,
    output logic [REG_W-1:0]            rf_rd,
    output logic [IDX_W-1:0]            rf_tag,
    output logic [31:0]                 rf_val,
    output logic                        store_commit,
    output logic                        bp_update,
    output logic [ADDR_W-1:0]           bp_pc,
    output logic                        bp_taken,
    output logic                        ras_en,
    output logic                        ras_push,
    output logic [ADDR_W-1:0]           ras_addr
);

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]  head, tail;
    logic [DEPTH-1:0]  valid_q, ready_q;

    logic [2:0]        type_q   [DEPTH];
    logic [REG_W-1:0]  rd_q     [DEPTH];
    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [ADDR_W-1:0] info_q   [DEPTH];
    logic [ADDR_W-1:0] ptgt_q   [DEPTH];
    logic              ptaken_q [DEPTH];
    logic              mis_q    [DEPTH];
    logic [31:0]       val_q    [DEPTH];

    logic [IDX_W-1:0]    wid  [WB_PORTS];
    logic [31:0]         wval [WB_PORTS];
    logic [WB_PORTS-1:0] wb_hit;

    logic [DEPTH-1:0]  avail;
    logic [31:0]       qv [DEPTH];

    logic              do_app, do_commit, mispred;
    logic [2:0]        h_type;
    logic [ADDR_W-1:0] h_pc, h_info, redirect;
    logic [31:0]       h_val;

    assign next_id = tail;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_app    = append_en && !full && !flush;
    assign do_commit = !empty && ready_q[head] && !flush;

    assign h_type = type_q[head];
    assign h_pc   = pc_q[head];
    assign h_info = info_q[head];
    assign h_val  = val_q[head];

    // Unpack writeback buses; a writeback only counts if its slot is live and no flush is in progress.
    always_comb begin
        for (int k = 0; k < WB_PORTS; k++) begin
            wid[k]    = wb_id[k*IDX_W +: IDX_W];
            wval[k]   = wb_val[k*32 +: 32];
            wb_hit[k] = wb_en[k] && valid_q[wid[k]] && !flush;
        end
    end

    // Head-entry mispredict detection and redirect target.
    always_comb begin
        mispred  = 1'b0;
        redirect = '0;
        case (h_type)
            ROB_BRANCH: begin
                mispred  = (h_val[0] != ptaken_q[head]);
                redirect = h_val[0] ? h_info : (h_pc + ADDR_W'(4));
            end
            ROB_JALR: begin
                mispred  = mis_q[head];
                redirect = h_val[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    // Per-entry query view: availability and the value a consumer should see (jal yields its link address).
    always_comb begin
        avail = valid_q & ready_q;
        for (int i = 0; i < DEPTH; i++) begin
            qv[i] = (type_q[i] == ROB_JAL) ? 32'(info_q[i]) : val_q[i];
        end
    end

    // Pointers, occupancy and valid/ready bits; a committing mispredict wipes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            if (do_app) begin
                valid_q[tail] <= 1'b1;
                ready_q[tail] <= (append_type == ROB_STORE) || (append_type == ROB_JAL);
                tail          <= tail + PTR_ONE;
            end
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_hit[k]) ready_q[wid[k]] <= 1'b1;
            end
            if (do_commit) begin
                valid_q[head] <= 1'b0;
                ready_q[head] <= 1'b0;
                head          <= head + PTR_ONE;
            end
            case ({do_app, do_commit})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
            if (do_commit && mispred) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                valid_q <= '0;
                ready_q <= '0;
            end
        end
    end

    // Entry payload; liveness is tracked by valid_q so these need no reset. Later ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (do_app) begin
            type_q[tail]   <= append_type;
            rd_q[tail]     <= append_rd;
            pc_q[tail]     <= append_pc;
            info_q[tail]   <= append_info;
            ptgt_q[tail]   <= append_pred_target;
            ptaken_q[tail] <= append_pred_taken;
            mis_q[tail]    <= 1'b0;
        end
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_hit[k]) begin
                val_q[wid[k]] <= wval[k];
                mis_q[wid[k]] <= (type_q[wid[k]] == ROB_JALR) &&
                                 (wval[k][ADDR_W-1:0] != ptgt_q[wid[k]]);
            end
        end
    end

    // Registered commit side effects: zero in any cycle without a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush        <= 1'b0;
            flush_pc     <= '0;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_tag       <= '0;
            rf_val       <= '0;
            store_commit <= 1'b0;
            bp_update    <= 1'b0;
            bp_pc        <= '0;
            bp_taken     <= 1'b0;
            ras_en       <= 1'b0;
            ras_push     <= 1'b0;
            ras_addr     <= '0;
        end else begin
            flush        <= 1'b0;
            flush_pc     <= '0;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_tag       <= '0;
            rf_val       <= '0;
            store_commit <= 1'b0;
            bp_update    <= 1'b0;
            bp_pc        <= '0;
            bp_taken     <= 1'b0;
            ras_en       <= 1'b0;
            ras_push     <= 1'b0;
            ras_addr     <= '0;
            if (do_commit) begin
                case (h_type)
                    ROB_ALU: begin
                        rf_we  <= 1'b1;
                        rf_rd  <= rd_q[head];
                        rf_tag <= head;
                        rf_val <= h_val;
                    end
                    ROB_STORE: store_commit <= 1'b1;
                    ROB_BRANCH: begin
                        bp_update <= 1'b1;
                        bp_pc     <= h_pc;
                        bp_taken  <= h_val[0];
                    end
                    ROB_JAL: begin
                        rf_we    <= 1'b1;
                        rf_rd    <= rd_q[head];
                        rf_tag   <= head;
                        rf_val   <= 32'(h_info);
                        ras_en   <= 1'b1;
                        ras_push <= 1'b1;
                        ras_addr <= h_info;
                    end
                    ROB_JALR: begin
                        rf_we  <= 1'b1;
                        rf_rd  <= rd_q[head];
                        rf_tag <= head;
                        rf_val <= 32'(h_info);
                        ras_en <= 1'b1;
                    end
                    default: ;
                endcase
                if (mispred) begin
                    flush    <= 1'b1;
                    flush_pc <= redirect;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_QUERY; g++) begin : g_qport
            rob_query_port #(
                .DEPTH    (DEPTH),
                .WB_PORTS (WB_PORTS)
            ) u_qport (
                .id      (q_id[g*IDX_W +: IDX_W]),
                .avail   (avail),
                .qv      (qv),
                .wb_hit  (wb_hit),
                .wb_id   (wid),
                .wb_val  (wval),
                .pending (q_pending[g]),
                .val     (q_val[g*32 +: 32])
            );
        end
    endgenerate

endmodule

// File: doc/reorder_buffer_p.md
# reorder_buffer_p

Parametrised in-order-commit reorder buffer for the out-of-order core. It sits between dispatch and the architectural register file, branch predictor and return-address stack. It generalises the fixed 32-entry, 3-writeback buffer in depth, writeback-port count, query-port count and address width. It adds an occupancy count, a registered one-cycle flush handshake, and compile-time selectable writeback-to-query bypass.

## Interface
- DEPTH, 32, entries; power of two, 4..64; IDX_W = $clog2(DEPTH)
- WB_PORTS, 3, result-bus writeback ports
- NUM_QUERY, 2, operand query ports
- ADDR_W, 17, PC/address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- append_en  in  1  allocate the entry at tail
- append_type  in  3  op type: 0 ALU, 1 store, 2 branch, 3 jal, 4 jalr
- append_rd  in  5  destination register
- append_pc  in  ADDR_W  instruction address
- append_info  in  ADDR_W  branch target (branch) or PC+4 (jal/jalr)
- append_pred_target  in  ADDR_W  predicted jalr target
- append_pred_taken  in  1  predicted branch direction
- wb_en  in  WB_PORTS  per-port writeback valid
- wb_id  in  WB_PORTS*IDX_W  per-port entry tag
- wb_val  in  WB_PORTS*32  per-port result
- q_id  in  NUM_QUERY*IDX_W  query tags
- q_pending  out  NUM_QUERY  1 = value not yet available
- q_val  out  NUM_QUERY*32  query value
- next_id  out  IDX_W  tag the next append receives (= tail)
- count  out  IDX_W+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- flush  out  1  one-cycle redirect pulse
- flush_pc  out  ADDR_W  redirect target
- rf_we, rf_rd (5), rf_tag (IDX_W), rf_val (32)  out  register-file commit
- store_commit  out  1  head store retires
- bp_update, bp_pc (ADDR_W), bp_taken  out  predictor training
- ras_en, ras_push (1), ras_addr (ADDR_W)  out  RAS update

## Operation
- Circular buffer with head and tail pointers and a count register. Tags are slot indices.
- Append is accepted when append_en && !full && !flush. It writes the slot at tail and advances tail. Ready is set at append for store and jal; all other types start not ready.
- Writeback on port k writes val and sets ready if entry wb_id[k] is valid. Writebacks to an invalid slot are dropped. On a same-tag collision, the highest-numbered port wins.
- jalr writeback also records mispredict = (wb_val[ADDR_W-1:0] != pred_target).
- Commit: at most one per cycle, when !empty && ready[head] && !flush. Outputs by type:
  - ALU: rf_we with rf_val = val.
  - Store: store_commit.
  - Branch: bp_update with bp_taken = val[0]. Mispredict when val[0] != pred_taken; flush_pc = val[0] ? info : pc+4.
  - jal: rf_we with rf_val = info; ras_en, ras_push=1, ras_addr = info.
  - jalr: rf_we with rf_val = info; ras_en, ras_push=0. Mispredict redirects to val[ADDR_W-1:0].
- Mispredict at commit:
  - The same edge clears head, tail and count, and the valid bits.
  - flush rises for exactly the next cycle.
  - While flush is high, append, writeback and commit are all ignored.
- Query:
  - Ready entry: q_val = val, except jal, which returns info.
  - Entry not ready: q_pending=1.

## Timing
- All commit, flush and predictor outputs are registered and are valid the cycle after the commit edge. They are 0 on reset and 0 in any cycle without a commit.
- next_id, count, full, empty and the query outputs are combinational from state.
- Append and commit in the same cycle: count is unchanged.
- Append to a full buffer is ignored. Pointers wrap modulo DEPTH.
- rst_n low clears pointers, count, valid/ready bits and all outputs asynchronously. Reset mid-commit drops the pending outputs.

## Configuration
- ROB_BYPASS_EN defined: a query whose tag matches an active writeback in the same cycle returns q_pending=0 and that wb_val, using the same port priority as writeback.
- ROB_BYPASS_EN undefined: queries see only registered state, so the result is visible one cycle after writeback.

## Structure
- rob_pkg: op-type localparams (ROB_ALU..ROB_JALR) and the 5-bit register-id width.
- One sub-module, rob_query_port, instantiated NUM_QUERY times: tag lookup plus optional bypass mux.

## Test plan
- Fill: append DEPTH ALU ops, none ready -> full=1, count=DEPTH, 33rd append ignored, next_id=0 (DEPTH=32).
- Retire: append ALU rd=5, write back 0x1234 on port 2 -> rf_we=1, rf_rd=5, rf_val=0x1234 one cycle after commit; empty=1.
- Branch mispredict: pred_taken=0, wb val=1, info=0x0100 -> flush=1 for exactly one cycle, flush_pc=0x0100; younger entries discarded, count=0; an append during the flush cycle is ignored.
- jalr: pred_target=0x0200, wb 0x0204 -> ras_push=0, flush_pc=0x0204; wb 0x0200 -> no flush.
- Bypass: query tag 3 in the same cycle as a port-0 writeback of tag 3 with 0xAA -> q_pending=0, q_val=0xAA with ROB_BYPASS_EN; q_pending=1 without it.
- Async reset: drop rst_n mid-commit with no clock edge -> all outputs 0 and empty=1 immediately.
